// File: rtl/ten_gbe_tx_packetiser_pkg.sv
// Shared types and constants for the 10GbE TX packetiser: FSM states,
// header field layout and a constant-friendly ceiling log2.
package ten_gbe_tx_packetiser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  // Header word layout: {channel, reserved zeros, sequence number}
  localparam int HDR_CH_W   = 8;
  localparam int HDR_RSVD_W = 24;
  localparam int HDR_SEQ_W  = 32;

  // Ceiling log2, usable in localparam expressions
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// A write into a full FIFO is accepted only when a pop happens in the
// same cycle; otherwise it is dropped and wr_drop pulses.
module pkt_sync_fifo
  import ten_gbe_tx_packetiser_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   fill,
  output logic          wr_drop
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && (fill != '0);
  assign do_wr   = wr_en && (!full || do_rd);
  assign wr_drop = wr_en && !do_wr;
  assign rd_data = mem[rd_ptr];

  // Storage array; left unreset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/ten_gbe_tx_packetiser.sv
// Multi-channel TX front end: buffers N_CH 64-bit streams, cuts them into
// fixed-length frames (optional header word + PKT_WORDS payload words),
// serves ready channels round-robin and respects tx_afull back-pressure.
module ten_gbe_tx_packetiser
  import ten_gbe_tx_packetiser_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int PKT_WORDS = 128,
  parameter int FIFO_AW   = 9,
  parameter int HDR_EN    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*64-1:0]  in_data,
  input  logic [N_CH*32-1:0]  ch_dest_ip,
  input  logic [N_CH*16-1:0]  ch_dest_port,
  output logic                tx_valid,
  output logic [63:0]         tx_data,
  output logic                tx_end_of_frame,
  output logic [31:0]         tx_dest_ip,
  output logic [15:0]         tx_dest_port,
  input  logic                tx_afull,
  input  logic                tx_overflow,
  output logic [N_CH-1:0]     ch_overflow,
  output logic [31:0]         pkt_count,
  output logic [15:0]         core_ovf_count
);

  localparam int CH_W = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam int WC_W = clog2(PKT_WORDS);

  tx_state_t state;
  tx_state_t state_next;

  logic [63:0]      fifo_rd_data [N_CH];
  logic [FIFO_AW:0] fifo_fill    [N_CH];
  logic [N_CH-1:0]  fifo_rd_en;
  logic [N_CH-1:0]  fifo_wr_drop;
  logic [N_CH-1:0]  eligible;

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  arb_ch;
  logic [CH_W-1:0]  cand;
  logic             arb_found;
  logic [CH_W-1:0]  ch_idx;
  logic [WC_W-1:0]  word_idx;
  logic             last_word;
  logic [31:0]      seq [N_CH];

  logic             start_frame;
  logic             emit_hdr;
  logic             emit_pay;
  logic             finish_frame;
  logic [63:0]      hdr_word;
  logic [63:0]      cur_data;

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      pkt_sync_fifo #(
        .AW (FIFO_AW),
        .DW (64)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid[c]),
        .wr_data (in_data[64*c +: 64]),
        .rd_en   (fifo_rd_en[c]),
        .rd_data (fifo_rd_data[c]),
        .fill    (fifo_fill[c]),
        .wr_drop (fifo_wr_drop[c])
      );
      assign fifo_rd_en[c] = emit_pay && (ch_idx == CH_W'(c));
      assign eligible[c]   = (fifo_fill[c] >= (FIFO_AW+1)'(PKT_WORDS));
    end
  endgenerate

  assign last_word = (word_idx == WC_W'(PKT_WORDS - 1));
  assign cur_data  = fifo_rd_data[ch_idx];
  assign hdr_word  = {HDR_CH_W'(ch_idx), {HDR_RSVD_W{1'b0}}, HDR_SEQ_W'(seq[ch_idx])};

  // Round-robin pick: first eligible channel at or after rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_ch    = cand;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and per-cycle action strobes
  always_comb begin
    state_next   = state;
    start_frame  = 1'b0;
    emit_hdr     = 1'b0;
    emit_pay     = 1'b0;
    finish_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !tx_afull && arb_found) begin
          start_frame = 1'b1;
          state_next  = (HDR_EN != 0) ? ST_HDR : ST_PAY;
        end
      end
      ST_HDR: begin
        if (!tx_afull) begin
          emit_hdr   = 1'b1;
          state_next = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!tx_afull) begin
          emit_pay = 1'b1;
          if (last_word) begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        finish_frame = 1'b1;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame context: served channel, destination, word index, rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_idx       <= '0;
      rr_ptr       <= '0;
      word_idx     <= '0;
      tx_dest_ip   <= '0;
      tx_dest_port <= '0;
    end else begin
      if (start_frame) begin
        ch_idx       <= arb_ch;
        word_idx     <= '0;
        tx_dest_ip   <= ch_dest_ip[32*arb_ch +: 32];
        tx_dest_port <= ch_dest_port[16*arb_ch +: 16];
      end else if (emit_pay) begin
        word_idx <= word_idx + 1'b1;
      end
      if (finish_frame) begin
        rr_ptr <= (ch_idx == CH_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
      end
    end
  end

  // Registered output beat towards the core
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      tx_end_of_frame <= 1'b0;
    end else begin
      tx_valid        <= emit_hdr || emit_pay;
      tx_end_of_frame <= emit_pay && last_word;
      if (emit_hdr) begin
        tx_data <= hdr_word;
      end else if (emit_pay) begin
        tx_data <= cur_data;
      end
    end
  end

  // Per-channel sequence numbers, bumped once a frame is fully sent
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        seq[i] <= '0;
      end
    end else if (finish_frame) begin
      seq[ch_idx] <= seq[ch_idx] + 32'd1;
    end
  end

  // Status: sticky drop flags, frame counter, saturating core overflow count
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_overflow    <= '0;
      pkt_count      <= '0;
      core_ovf_count <= '0;
    end else begin
      ch_overflow <= ch_overflow | fifo_wr_drop;
      if (finish_frame) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (tx_overflow && (core_ovf_count != 16'hFFFF)) begin
        core_ovf_count <= core_ovf_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ten_gbe_tx_packetiser.sv
// Directed self-checking bench for ten_gbe_tx_packetiser with a 4-channel,
// 8-word-frame configuration.
module tb_ten_gbe_tx_packetiser;

  localparam int N_CH = 4;
  localparam int PKT  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH*64-1:0] in_data;
  logic [N_CH*32-1:0] ch_dest_ip;
  logic [N_CH*16-1:0] ch_dest_port;
  logic               tx_valid;
  logic [63:0]        tx_data;
  logic               tx_end_of_frame;
  logic [31:0]        tx_dest_ip;
  logic [15:0]        tx_dest_port;
  logic               tx_afull;
  logic               tx_overflow;
  logic [N_CH-1:0]    ch_overflow;
  logic [31:0]        pkt_count;
  logic [15:0]        core_ovf_count;

  int total = 0;
  int bad   = 0;
  int afull_valid = 0;

  typedef struct {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
  } cap_t;

  cap_t cap_q[$];

  typedef struct {
    int          ch;
    int          tag;
    logic [63:0] exp_hdr;
    logic [31:0] exp_ip;
    logic [15:0] exp_port;
    logic [31:0] exp_pkts;
  } vec_t;

  vec_t vecs[6];

  ten_gbe_tx_packetiser #(
    .N_CH      (N_CH),
    .PKT_WORDS (PKT),
    .FIFO_AW   (9),
    .HDR_EN    (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .ch_dest_ip      (ch_dest_ip),
    .ch_dest_port    (ch_dest_port),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_dest_ip      (tx_dest_ip),
    .tx_dest_port    (tx_dest_port),
    .tx_afull        (tx_afull),
    .tx_overflow     (tx_overflow),
    .ch_overflow     (ch_overflow),
    .pkt_count       (pkt_count),
    .core_ovf_count  (core_ovf_count)
  );

  // Free-running fabric clock
  always #5 clk = ~clk;

  // Output monitor: captures every valid beat away from the rising edge
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      cap_q.push_back('{data: tx_data, eof: tx_end_of_frame, ip: tx_dest_ip, port: tx_dest_port});
      if (tx_afull) begin
        afull_valid = afull_valid + 1;
      end
    end
  end

  function automatic logic [63:0] mk_data(input int ch, input int tag, input int idx);
    return {16'hDA7A, 8'(ch), 8'(tag), 32'(idx)};
  endfunction

  function automatic int count_eofs();
    int n;
    n = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i].eof) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Push n words into one channel, one per cycle
  task automatic applyStimulus(input int ch, input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      in_valid = '0;
      in_valid[ch] = 1'b1;
      in_data[64*ch +: 64] = mk_data(ch, tag, i);
      tick();
    end
    in_valid = '0;
  endtask

  task automatic write_all(input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      in_valid = '1;
      for (int c = 0; c < N_CH; c++) begin
        in_data[64*c +: 64] = mk_data(c, tag, i);
      end
      tick();
    end
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic wait_eofs(input int n, input int max_cycles);
    int cyc;
    cyc = 0;
    while (count_eofs() < n && cyc < max_cycles) begin
      tick();
      cyc++;
    end
    if (count_eofs() < n) checkOutput("eof_timeout", 64'(count_eofs()), 64'(n));
  endtask

  task automatic wait_words(input int n, input int max_cycles);
    int cyc;
    cyc = 0;
    while (cap_q.size() < n && cyc < max_cycles) begin
      tick();
      cyc++;
    end
    if (cap_q.size() < n) checkOutput("word_timeout", 64'(cap_q.size()), 64'(n));
  endtask

  task automatic check_frame(input int base, input int ch, input int tag, input int first_idx,
                             input logic [63:0] exp_hdr, input logic [31:0] exp_ip,
                             input logic [15:0] exp_port);
    if (cap_q.size() < base + PKT + 1) begin
      checkOutput("frame_len", 64'(cap_q.size()), 64'(base + PKT + 1));
      return;
    end
    checkOutput("hdr", cap_q[base].data, exp_hdr);
    checkOutput("hdr_eof", 64'(cap_q[base].eof), 64'd0);
    checkOutput("dest_ip", 64'(cap_q[base].ip), 64'(exp_ip));
    checkOutput("dest_port", 64'(cap_q[base].port), 64'(exp_port));
    for (int i = 0; i < PKT; i++) begin
      checkOutput("payload", cap_q[base+1+i].data, mk_data(ch, tag, first_idx + i));
      checkOutput("eof", 64'(cap_q[base+1+i].eof), 64'(i == PKT - 1));
    end
    checkOutput("dest_ip_last", 64'(cap_q[base+PKT].ip), 64'(exp_ip));
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    in_valid     = '0;
    in_data      = '0;
    tx_afull     = 1'b0;
    tx_overflow  = 1'b0;
    ch_dest_ip   = {32'h0A000103, 32'h0A000102, 32'h0A000101, 32'h0A000100};
    ch_dest_port = {16'd5003, 16'd5002, 16'd5001, 16'd5000};

    vecs[0] = '{ch: 2, tag: 1, exp_hdr: 64'h02000000_00000000, exp_ip: 32'h0A000102, exp_port: 16'd5002, exp_pkts: 32'd1};
    vecs[1] = '{ch: 0, tag: 2, exp_hdr: 64'h00000000_00000000, exp_ip: 32'h0A000100, exp_port: 16'd5000, exp_pkts: 32'd2};
    vecs[2] = '{ch: 2, tag: 3, exp_hdr: 64'h02000000_00000001, exp_ip: 32'h0A000102, exp_port: 16'd5002, exp_pkts: 32'd3};
    vecs[3] = '{ch: 3, tag: 4, exp_hdr: 64'h03000000_00000000, exp_ip: 32'h0A000103, exp_port: 16'd5003, exp_pkts: 32'd4};
    vecs[4] = '{ch: 1, tag: 5, exp_hdr: 64'h01000000_00000000, exp_ip: 32'h0A000101, exp_port: 16'd5001, exp_pkts: 32'd5};
    vecs[5] = '{ch: 2, tag: 6, exp_hdr: 64'h02000000_00000002, exp_ip: 32'h0A000102, exp_port: 16'd5002, exp_pkts: 32'd6};

    tick();
    do_reset();

    $display("[TB] reset state");
    checkOutput("rst_valid", 64'(tx_valid), 64'd0);
    checkOutput("rst_data", tx_data, 64'd0);
    checkOutput("rst_eof", 64'(tx_end_of_frame), 64'd0);
    checkOutput("rst_ip", 64'(tx_dest_ip), 64'd0);
    checkOutput("rst_port", 64'(tx_dest_port), 64'd0);
    checkOutput("rst_ch_ovf", 64'(ch_overflow), 64'd0);
    checkOutput("rst_pkts", 64'(pkt_count), 64'd0);
    checkOutput("rst_core_ovf", 64'(core_ovf_count), 64'd0);

    $display("[TB] core overflow counter");
    tx_overflow = 1'b1;
    tick();
    tick();
    tick();
    tx_overflow = 1'b0;
    tick();
    checkOutput("core_ovf_count", 64'(core_ovf_count), 64'd3);

    $display("[TB] single-channel frame table");
    for (int v = 0; v < 6; v++) begin
      cap_q.delete();
      applyStimulus(vecs[v].ch, PKT, vecs[v].tag);
      wait_eofs(1, 100);
      tick();
      tick();
      checkOutput("frame_words", 64'(cap_q.size()), 64'(PKT + 1));
      check_frame(0, vecs[v].ch, vecs[v].tag, 0, vecs[v].exp_hdr, vecs[v].exp_ip, vecs[v].exp_port);
      checkOutput("pkt_count", 64'(pkt_count), 64'(vecs[v].exp_pkts));
    end

    $display("[TB] round-robin with all channels ready");
    do_reset();
    write_all(2 * PKT, 7);
    wait_eofs(8, 400);
    checkOutput("rr_words", 64'(cap_q.size()), 64'(8 * (PKT + 1)));
    for (int f = 0; f < 8; f++) begin
      int ch;
      int sq;
      ch = f % N_CH;
      sq = f / N_CH;
      check_frame(f * (PKT + 1), ch, 7, sq * PKT, {8'(ch), 24'h0, 32'(sq)},
                  32'h0A000100 + 32'(ch), 16'(5000 + ch));
    end

    $display("[TB] back-pressure mid-payload");
    do_reset();
    applyStimulus(1, PKT, 8);
    wait_words(4, 50);
    afull_valid = 0;
    tx_afull = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_afull = 1'b0;
    checkOutput("afull_beats", 64'(afull_valid <= 1), 64'd1);
    wait_eofs(1, 100);
    tick();
    tick();
    checkOutput("afull_words", 64'(cap_q.size()), 64'(PKT + 1));
    check_frame(0, 1, 8, 0, 64'h01000000_00000000, 32'h0A000101, 16'd5001);

    $display("[TB] FIFO overflow on channel 1");
    do_reset();
    enable = 1'b0;
    applyStimulus(1, 513, 9);
    tick();
    checkOutput("ch_overflow", 64'(ch_overflow), 64'h2);
    checkOutput("ch1_fill", 64'(dut.fifo_fill[1]), 64'd512);
    checkOutput("ovf_no_tx", 64'(cap_q.size()), 64'd0);
    do_reset();
    checkOutput("ch_overflow_clr", 64'(ch_overflow), 64'd0);

    $display("[TB] enable drop mid-frame");
    applyStimulus(0, 2 * PKT, 10);
    enable = 1'b1;
    wait_words(4, 50);
    enable = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checkOutput("en_words", 64'(cap_q.size()), 64'(PKT + 1));
    checkOutput("en_eofs", 64'(count_eofs()), 64'd1);
    check_frame(0, 0, 10, 0, 64'h00000000_00000000, 32'h0A000100, 16'd5000);
    checkOutput("en_pkts", 64'(pkt_count), 64'd1);

    $display("[TB] reset mid-frame");
    do_reset();
    applyStimulus(3, 2 * PKT, 11);
    enable = 1'b1;
    wait_eofs(1, 100);
    wait_words(PKT + 1 + 5, 50);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_valid", 64'(tx_valid), 64'd0);
    checkOutput("mid_rst_eof", 64'(tx_end_of_frame), 64'd0);
    checkOutput("mid_rst_pkts", 64'(pkt_count), 64'd0);
    checkOutput("mid_rst_ip", 64'(tx_dest_ip), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_rst_eofs", 64'(count_eofs()), 64'd1);
    cap_q.delete();
    applyStimulus(3, PKT, 12);
    wait_eofs(1, 100);
    tick();
    tick();
    checkOutput("post_rst_words", 64'(cap_q.size()), 64'(PKT + 1));
    check_frame(0, 3, 12, 0, 64'h03000000_00000000, 32'h0A000103, 16'd5003);
    checkOutput("post_rst_pkts", 64'(pkt_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
